// File: rtl/watch_mode_ctrl.sv
// Watch front-panel controller: button edges drive mode selection and a digit-cursor
// edit session with blinking, and the selected source is registered out to the display.
module watch_mode_ctrl #(
  parameter int                    NUM_DIGITS = 4,
  parameter int                    NUM_MODES  = 4,
  parameter logic [NUM_MODES-1:0]  EDIT_MASK  = NUM_MODES'(4'b0101),
  parameter int                    BLINK_HALF = 25_000_000,
  localparam int                   MW = $clog2(NUM_MODES),
  localparam int                   DW = $clog2(NUM_DIGITS),
  localparam int                   CW = $clog2(BLINK_HALF),
  localparam int                   SW = NUM_DIGITS*4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode_btn,
  input  logic                        set_btn,
  input  logic                        next_btn,
  input  logic                        up_btn,
  input  logic [NUM_MODES*SW-1:0]     src_digits,
  output logic [MW-1:0]               mode,
  output logic                        edit_active,
  output logic [DW-1:0]               edit_sel,
  output logic                        edit_up,
  output logic                        edit_commit,
  output logic                        edit_abort,
  output logic [SW-1:0]               dis,
  output logic [NUM_DIGITS-1:0]       blank
);

  typedef enum logic [1:0] {VIEW, EDIT, COMMIT} state_t;

  state_t          state, state_nx;
  logic [3:0]      btn, prev, rise;
  logic [MW-1:0]   mode_nx;
  logic [DW-1:0]   sel_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            phase_off, phase_nx;
  logic            up_nx, commit_nx, abort_nx;
  logic [SW-1:0]   src_arr [NUM_MODES];

  for (genvar m = 0; m < NUM_MODES; m++) begin : g_src
    assign src_arr[m] = src_digits[m*SW +: SW];
  end

  // bit order: 0 mode, 1 set, 2 next, 3 up
  assign btn  = {up_btn, next_btn, set_btn, mode_btn};
  assign rise = btn & ~prev;

  always_comb begin
    state_nx  = state;
    mode_nx   = mode;
    sel_nx    = edit_sel;
    up_nx     = 1'b0;
    commit_nx = 1'b0;
    abort_nx  = 1'b0;
    cnt_nx    = '0;
    phase_nx  = 1'b0;
    if (state == EDIT) begin
      if (cnt == CW'(BLINK_HALF-1)) begin
        cnt_nx   = '0;
        phase_nx = ~phase_off;
      end else begin
        cnt_nx   = cnt + 1'b1;
        phase_nx = phase_off;
      end
    end
    // a set rise shadows every other rise in the same cycle, even when ignored
    case (state)
      VIEW: begin
        if (rise[1]) begin
          if (EDIT_MASK[mode]) begin
            state_nx = EDIT;
            sel_nx   = DW'(NUM_DIGITS-1);
          end
        end else if (rise[0]) begin
          mode_nx = (mode == MW'(NUM_MODES-1)) ? '0 : mode + 1'b1;
        end
      end
      EDIT: begin
        if (rise[1]) begin
          state_nx  = COMMIT;
          commit_nx = 1'b1;
        end else if (rise[0]) begin
          state_nx = VIEW;
          abort_nx = 1'b1;
        end else if (rise[2]) begin
          sel_nx   = (edit_sel == '0) ? DW'(NUM_DIGITS-1) : edit_sel - 1'b1;
          cnt_nx   = '0;
          phase_nx = 1'b0;
        end else if (rise[3]) begin
          up_nx    = 1'b1;
          cnt_nx   = '0;
          phase_nx = 1'b0;
        end
      end
      COMMIT:  state_nx = VIEW;
      default: state_nx = VIEW;
    endcase
    if (state_nx != EDIT) begin
      cnt_nx   = '0;
      phase_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= VIEW;
      prev        <= '1;
      mode        <= '0;
      edit_sel    <= '0;
      cnt         <= '0;
      phase_off   <= 1'b0;
      edit_up     <= 1'b0;
      edit_commit <= 1'b0;
      edit_abort  <= 1'b0;
      dis         <= '0;
    end else begin
      state       <= state_nx;
      prev        <= btn;
      mode        <= mode_nx;
      edit_sel    <= sel_nx;
      cnt         <= cnt_nx;
      phase_off   <= phase_nx;
      edit_up     <= up_nx;
      edit_commit <= commit_nx;
      edit_abort  <= abort_nx;
      dis         <= src_arr[mode];
    end
  end

  assign edit_active = (state == EDIT);

  always_comb begin
    blank = '0;
    if (state == EDIT && phase_off) blank[edit_sel] = 1'b1;
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed front-panel scenarios then random button traffic,
// every cycle compared against a cycle-count/modulo reference model.
module tb_watch_mode_ctrl;
  localparam int ND = 4, NM = 4, BH = 4;
  localparam logic [3:0] MASK = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  b = '0;             // 0 mode, 1 set, 2 next, 3 up
  logic [63:0] src = '0;
  logic [1:0]  mode;
  logic        edit_active, edit_up, edit_commit, edit_abort;
  logic [1:0]  edit_sel;
  logic [15:0] dis;
  logic [3:0]  blank;

  int errors = 0, checks = 0;

  // reference model: st 0=view 1=edit 2=commit; age = cycles since blink restart
  int       m_mode, m_st, m_sel, m_age;
  bit       m_up, m_commit, m_abort;
  bit [3:0] m_prev;
  logic [15:0] m_dis;

  watch_mode_ctrl #(.NUM_DIGITS(ND), .NUM_MODES(NM), .EDIT_MASK(MASK), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mode_btn(b[0]), .set_btn(b[1]), .next_btn(b[2]), .up_btn(b[3]),
    .src_digits(src),
    .mode(mode), .edit_active(edit_active), .edit_sel(edit_sel),
    .edit_up(edit_up), .edit_commit(edit_commit), .edit_abort(edit_abort),
    .dis(dis), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit [3:0] r;
    int ns;
    if (!rst_n) begin
      m_mode = 0; m_st = 0; m_sel = 0; m_age = 0;
      m_up = 0; m_commit = 0; m_abort = 0; m_dis = '0; m_prev = 4'hF;
    end else begin
      r = b & ~m_prev;
      ns = m_st;
      m_dis = 16'((src >> (m_mode*16)) & 64'hFFFF);
      m_up = 0; m_commit = 0; m_abort = 0;
      if (m_st == 1) m_age++;
      if (m_st == 0) begin
        if (r[1]) begin
          if (MASK[m_mode]) begin ns = 1; m_sel = ND-1; m_age = 0; end
        end else if (r[0]) m_mode = (m_mode + 1) % NM;
      end else if (m_st == 1) begin
        if (r[1])      begin ns = 2; m_commit = 1; end
        else if (r[0]) begin ns = 0; m_abort = 1; end
        else if (r[2]) begin m_sel = (m_sel + ND - 1) % ND; m_age = 0; end
        else if (r[3]) begin m_up = 1; m_age = 0; end
      end else ns = 0;
      m_st = ns;
      if (m_st != 1) m_age = 0;
      m_prev = b;
    end
  endtask

  task automatic cyc(input int n);
    int exp_blank;
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      exp_blank = (m_st == 1 && ((m_age / BH) % 2) == 1) ? (1 << m_sel) : 0;
      chk("mode", 32'(mode), 32'(m_mode));
      chk("edit_active", 32'(edit_active), 32'(m_st == 1));
      chk("edit_sel", 32'(edit_sel), 32'(m_sel));
      chk("edit_up", 32'(edit_up), 32'(m_up));
      chk("edit_commit", 32'(edit_commit), 32'(m_commit));
      chk("edit_abort", 32'(edit_abort), 32'(m_abort));
      chk("dis", 32'(dis), 32'(m_dis));
      chk("blank", 32'(blank), 32'(exp_blank));
    end
  endtask

  task automatic press(input int i);
    b[i] = 1'b1; cyc(2);
    b[i] = 1'b0; cyc(2);
  endtask

  initial begin
    src = {16'hABCD, 16'h0789, 16'h0590, 16'h1234};
    b[0] = 1'b1;                        // mode held through reset release
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("mode_held_no_edge", 32'(mode), 32'd0);
    b[0] = 1'b0; cyc(2);
    press(0);
    chk("mode_after_press", 32'(mode), 32'd1);
    press(0); press(0); press(0);
    chk("mode_wrapped", 32'(mode), 32'd0);

    // edit session in mode 0: blink, cursor walk, increment, commit
    press(1);
    cyc(12);
    press(2); press(2); press(2); press(2);
    press(3);
    press(1);
    cyc(3);

    // non-editable mode 1, then abort in mode 2
    press(0); press(1); cyc(2);
    press(0); press(1); cyc(3); press(0);
    chk("mode_after_abort", 32'(mode), 32'd2);
    press(0); press(0);

    // simultaneous set and up inside edit
    press(1);
    b[1] = 1'b1; b[3] = 1'b1; cyc(2);
    b = '0; cyc(2);

    // reset mid-edit
    press(1); cyc(5);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(3);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
      if ($urandom_range(0, 40) == 0) src = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 700) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
- Parametrised watch front-panel controller for NUM_MODES sources (watch, stopwatch, alarm, day, …), each NUM_DIGITS BCD digits wide.
- Turns raw button levels into mode selection and a digit-cursor edit session with blinking, and emits registered display digits to the seven-segment decoders.
- Edit requests go to the owning timekeeping modules as single-cycle strobes.
- Sits between the mode sources and the SevenSegDecoder instances.

Parameters:
- NUM_DIGITS, 4: display digits per mode; must be ≥ 2.
- NUM_MODES, 4: number of selectable modes; must be ≥ 2.
- EDIT_MASK, 4'b0101: bit m = 1 means mode m is editable.
- BLINK_HALF, 25_000_000: clock cycles per blink half-period; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_btn  in  1  level, synchronous to clk; rising edge advances the mode.
- set_btn  in  1  level; rising edge enters or commits an edit.
- next_btn  in  1  level; rising edge moves the edit cursor.
- up_btn  in  1  level; rising edge requests a digit increment.
- src_digits  in  NUM_MODES*NUM_DIGITS*4  mode m, digit d at bits [(m*NUM_DIGITS+d)*4 +: 4]; digit 0 is least significant.
- mode  out  clog2(NUM_MODES)  current mode index.
- edit_active  out  1  high while in EDIT.
- edit_sel  out  clog2(NUM_DIGITS)  cursor digit index.
- edit_up  out  1  one-cycle increment strobe, qualified by mode and edit_sel.
- edit_commit  out  1  one-cycle strobe: accept the edited value.
- edit_abort  out  1  one-cycle strobe: discard the edited value.
- dis  out  NUM_DIGITS*4  registered digits to the decoders.
- blank  out  NUM_DIGITS  1 = decoder shows dark for that digit.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - mode = 0, state = VIEW, edit_sel = 0, all strobes = 0.
  - dis = 0, blank = 0, blink counter = 0, blink phase = ON.
  - Button history registers reset to 1, so a button held through reset release produces no edge until it is released and pressed again.
- Edge detect: rise_x = btn_x & ~prev_x. Every button is sampled each cycle.
- Priority when several rises occur in one cycle: set > mode > next > up. Lower-priority rises in that cycle are dropped.
- States: VIEW, EDIT, COMMIT.
- VIEW:
  - mode rise: mode <= (mode == NUM_MODES-1) ? 0 : mode+1.
  - set rise with EDIT_MASK[mode] = 1: go to EDIT, edit_sel <= NUM_DIGITS-1, blink counter <= 0, phase <= ON.
  - set rise with EDIT_MASK[mode] = 0: ignored.
  - next and up rises: ignored.
- EDIT:
  - next rise: edit_sel <= (edit_sel == 0) ? NUM_DIGITS-1 : edit_sel-1; counter <= 0, phase <= ON.
  - up rise: edit_up = 1 for exactly one cycle, edit_sel unchanged; counter <= 0, phase <= ON.
  - set rise: go to COMMIT.
  - mode rise: edit_abort = 1 for one cycle, go to VIEW, mode unchanged.
- COMMIT:
  - edit_commit = 1 for this single cycle, then unconditionally VIEW.
  - All button rises in this cycle are ignored.
- Strobe timing: edit_up, edit_commit and edit_abort are registered and assert the cycle after the detected rise. They are mutually exclusive.
- Blink (EDIT only):
  - Counter runs 0..BLINK_HALF-1; phase toggles on wrap.
  - blank[edit_sel] = (phase == OFF). All other blank bits = 0.
  - Outside EDIT: blank = 0; counter held at 0, phase = ON.
- Display path: dis <= src_digits slice of the current mode, one-cycle latency. A mode change shows the new source on the cycle after mode updates. dis is not frozen during EDIT; the source module reflects pending edits.
- Width rules: mode and edit_sel wrap explicitly (no reliance on power-of-two overflow). src_digits values above 9 pass through unchanged.
- Reset mid-edit: returns to VIEW, mode 0, with no commit or abort strobe.

Test Plan:
- Reset with mode_btn held high, release rst_n, keep button high 10 cycles -> mode stays 0. Release then press -> mode = 1; after 3 more presses -> wraps to 0.
- Mode 0, src digits 1,2,3,4 (d3..d0) -> dis = 0x1234 one cycle after selection. Switch to mode 1 with digits 0x0590 -> dis = 0x0590 on the cycle after mode becomes 1.
- BLINK_HALF = 4, mode 0, press set -> edit_active = 1, edit_sel = 3, blank = 0000 for 4 cycles then 1000 for 4 cycles, repeating. Press next 4 times -> edit_sel sequence 2, 1, 0, 3, with blank reset to 0 on each move.
- In EDIT: up rise -> single-cycle edit_up with edit_sel = 3. Set rise -> edit_commit high exactly 1 cycle, then edit_active = 0, blank = 0.
- Mode 1 (non-editable), press set -> no state change, no strobes. Mode 2 in EDIT, press mode -> edit_abort 1 cycle, mode stays 2.
- Same-cycle set and up rise in EDIT -> COMMIT only, edit_up never asserted. rst_n pulsed low mid-EDIT -> all outputs at reset values, no strobes.
